// File: rtl/main_mem_responder.sv
// ---------------------------------------------------------------------------
// main_mem_responder
//
// Main-memory responder for the cache controller's miss/writeback bus.
// It samples a read or write request in IDLE and waits LATENCY cycles. A read
// then bursts one aligned cache block out of word-wide storage, one word per
// cycle. A write commits a single 32-bit word. Completion is signalled by a
// one-cycle main_mem_ready pulse.
//
// Parameters
//   DEPTH_WORDS  storage depth in 32-bit words (power of two)
//   LATENCY      wait cycles before the access starts (1..15)
//   BLOCK_WORDS  words per cache block, i.e. read burst length (2..16)
//
// Ports
//   clk                 in   1    single clock, rising edge
//   rst                 in   1    synchronous reset, active-high
//   main_mem_addr       in   32   byte address from the controller
//   main_mem_data_out   in   32   write data from the controller
//   main_mem_read_req   in   1    block read request (level)
//   main_mem_write_req  in   1    word write request (level)
//   main_mem_data_in    out  512  read block; word k at bits [k*32+:32]
//   main_mem_ready      out  1    one-cycle completion pulse
//   mm_busy             out  1    high whenever the FSM is not in IDLE
//   mm_err              out  1    address-range error, high with ready
//
// Optional feature: define MM_RANGE_CHECK_EN to flag requests with
// addr >= DEPTH_WORDS*4. Such a write leaves storage untouched, such a read
// returns zeros, and mm_err rises together with ready. When the macro is
// undefined, upper address bits wrap and mm_err is tied low.
// ---------------------------------------------------------------------------
module main_mem_responder #(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 4,
  parameter int BLOCK_WORDS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               main_mem_addr,
  input  logic [31:0]               main_mem_data_out,
  input  logic                      main_mem_read_req,
  input  logic                      main_mem_write_req,
  output logic [BLOCK_WORDS*32-1:0] main_mem_data_in,
  output logic                      main_mem_ready,
  output logic                      mm_busy,
  output logic                      mm_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int OFF_W = $clog2(BLOCK_WORDS);

  // Terminal counts for the 4-bit phase counter.
  localparam logic [3:0] LAT_LAST   = 4'(LATENCY - 1);
  localparam logic [3:0] BURST_LAST = 4'(BLOCK_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_BURST,
    S_WR_WAIT,
    S_DONE
  } state_t;

  state_t                    r_state;
  logic [3:0]                r_cnt;
  logic [IDX_W-1:0]          r_idx;      // latched word index
  logic [31:0]               r_wdata;    // latched write data
  logic                      r_ready;
  logic                      r_busy;
  logic [BLOCK_WORDS*32-1:0] r_data_in;

  // NOTE: storage is deliberately left out of reset; clearing a RAM array on
  // reset would stop it mapping onto memory macros, and its contents must
  // survive reset anyway.
  logic [31:0]               r_mem [DEPTH_WORDS];

  logic [IDX_W-1:0]          w_rd_idx;
  logic [31:0]               w_rd_word;
  logic                      w_mem_we;
  logic                      w_oor_now;  // out-of-range decision at sample time
  logic                      w_oor;      // out-of-range flag of the current request

`ifdef MM_RANGE_CHECK_EN
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);

  logic r_oor;
  logic r_err;

  assign w_oor_now = (main_mem_addr >= ADDR_LIMIT);
  assign w_oor     = r_oor;
  assign mm_err    = r_err;
`else
  // Upper address bits simply wrap; no request is ever out of range.
  assign w_oor_now = 1'b0;
  assign w_oor     = 1'b0;
  assign mm_err    = 1'b0;
`endif

  // Byte-offset bits and (without range checking) the upper address bits
  // carry no meaning for this memory.
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{main_mem_addr[31:IDX_W+2], main_mem_addr[1:0], w_oor_now};

  // The burst stays inside the aligned block: the upper index bits come from
  // the latched address and the low bits from the beat counter.
  assign w_rd_idx  = {r_idx[IDX_W-1:OFF_W], r_cnt[OFF_W-1:0]};
  assign w_rd_word = w_oor ? 32'h0 : r_mem[w_rd_idx];

  // The write lands on the last WR_WAIT edge. It is gated by rst so that a
  // reset on that same edge still discards the pending write.
  assign w_mem_we = (r_state == S_WR_WAIT) && (r_cnt == LAT_LAST) && !w_oor && !rst;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  // Control FSM with registered outputs. r_idx / r_wdata are plain data
  // latches: their value is irrelevant until the next request samples them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_data_in <= '0;
`ifdef MM_RANGE_CHECK_EN
      r_err     <= 1'b0;
`endif
    end else begin
      r_ready <= 1'b0;
`ifdef MM_RANGE_CHECK_EN
      r_err   <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          // Read wins when both requests are high; the write is not latched.
          if (main_mem_read_req) begin
            r_idx   <= main_mem_addr[IDX_W+1:2];
            r_cnt   <= 4'd0;
            r_busy  <= 1'b1;
            r_state <= S_RD_WAIT;
`ifdef MM_RANGE_CHECK_EN
            r_oor   <= w_oor_now;
`endif
          end else if (main_mem_write_req) begin
            r_idx   <= main_mem_addr[IDX_W+1:2];
            r_wdata <= main_mem_data_out;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b1;
            r_state <= S_WR_WAIT;
`ifdef MM_RANGE_CHECK_EN
            r_oor   <= w_oor_now;
`endif
          end
        end

        S_RD_WAIT: begin
          if (r_cnt == LAT_LAST) begin
            r_cnt   <= 4'd0;
            r_state <= S_RD_BURST;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end

        S_RD_BURST: begin
          r_data_in[r_cnt*32 +: 32] <= w_rd_word;
          if (r_cnt == BURST_LAST) begin
            r_cnt   <= 4'd0;
            r_ready <= 1'b1;
            r_state <= S_DONE;
`ifdef MM_RANGE_CHECK_EN
            r_err   <= r_oor;
`endif
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end

        S_WR_WAIT: begin
          if (r_cnt == LAT_LAST) begin
            r_cnt   <= 4'd0;
            r_ready <= 1'b1;
            r_state <= S_DONE;
`ifdef MM_RANGE_CHECK_EN
            r_err   <= r_oor;
`endif
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end

        S_DONE: begin
          // The requester drops its request during DONE. IDLE then lasts at
          // least one cycle before the next request is sampled.
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_cnt   <= 4'd0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign main_mem_data_in = r_data_in;
  assign main_mem_ready   = r_ready;
  assign mm_busy          = r_busy;

endmodule

// File: tb/tb_main_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_main_mem_responder
//
// Directed testbench for main_mem_responder at the default parameters
// (LATENCY=4, BLOCK_WORDS=16). Cycle 1 is the cycle after the edge that
// samples a request, so a read completes in cycle 21 and a write in cycle 5.
// Expectations that depend on MM_RANGE_CHECK_EN follow the same macro.
// ---------------------------------------------------------------------------
module tb_main_mem_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  main_mem_addr;
  logic [31:0]  main_mem_data_out;
  logic         main_mem_read_req;
  logic         main_mem_write_req;
  logic [511:0] main_mem_data_in;
  logic         main_mem_ready;
  logic         mm_busy;
  logic         mm_err;

  int checks = 0;
  int errors = 0;

`ifdef MM_RANGE_CHECK_EN
  localparam logic EXP_OOR_ERR = 1'b1;
`else
  localparam logic EXP_OOR_ERR = 1'b0;
`endif

  main_mem_responder dut (
    .clk                (clk),
    .rst                (rst),
    .main_mem_addr      (main_mem_addr),
    .main_mem_data_out  (main_mem_data_out),
    .main_mem_read_req  (main_mem_read_req),
    .main_mem_write_req (main_mem_write_req),
    .main_mem_data_in   (main_mem_data_in),
    .main_mem_ready     (main_mem_ready),
    .mm_busy            (mm_busy),
    .mm_err             (mm_err)
  );

  always #5 clk = ~clk;

  // Runs one request and reports what it saw. The task is entered and left
  // 1 time unit after a rising edge. It waits for IDLE first, so consecutive
  // calls run back to back with the minimum one-cycle IDLE gap.
  task automatic do_req(input logic rd_i, input logic wr_i,
                        input logic [31:0] a, input logic [31:0] d,
                        input bit toggle_rd,
                        output int lat, output int busy_bad,
                        output int err_bad, output logic err_at_ready);
    int n;
    lat          = -1;
    busy_bad     = 0;
    err_bad      = 0;
    err_at_ready = 1'b0;
    n = 0;
    while (mm_busy !== 1'b0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    main_mem_addr      = a;
    main_mem_data_out  = d;
    main_mem_read_req  = rd_i;
    main_mem_write_req = wr_i;
    @(posedge clk); #1;
    for (int c = 1; c <= 200; c++) begin
      if (mm_busy !== 1'b1) busy_bad++;
      if (main_mem_ready === 1'b1) begin
        lat          = c;
        err_at_ready = mm_err;
        break;
      end
      if (mm_err !== 1'b0) err_bad++;
      if (toggle_rd) main_mem_read_req = ~main_mem_read_req;
      @(posedge clk); #1;
    end
    main_mem_read_req  = 1'b0;
    main_mem_write_req = 1'b0;
  endtask

  task automatic test_reset();
    rst                = 1'b1;
    main_mem_addr      = '0;
    main_mem_data_out  = '0;
    main_mem_read_req  = 1'b0;
    main_mem_write_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (main_mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", main_mem_ready); end
    checks++; if (mm_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", mm_busy); end
    checks++; if (mm_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", mm_err); end
    checks++; if (main_mem_data_in !== 512'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", main_mem_data_in); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Read of an untouched block: all-zero data, full read latency.
  task automatic test_read_cold();
    int lat, bb, eb;
    logic e;
    do_req(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, lat, bb, eb, e);
    checks++; if (lat !== 21) begin errors++; $display("FAIL cold_read_latency: got %0d expected 21", lat); end
    checks++; if (bb !== 0) begin errors++; $display("FAIL cold_read_busy: %0d cycles low, expected 0", bb); end
    checks++; if (eb !== 0 || e !== 1'b0) begin errors++; $display("FAIL cold_read_err: stray %0d at_ready %b expected 0/0", eb, e); end
    checks++; if (main_mem_data_in !== 512'h0) begin errors++; $display("FAIL cold_read_data: got %h expected 0", main_mem_data_in); end
    @(posedge clk); #1;
    checks++; if (main_mem_ready !== 1'b0 || mm_busy !== 1'b0) begin errors++; $display("FAIL cold_read_after: ready %b busy %b expected 0 0", main_mem_ready, mm_busy); end
  endtask

  // Write word 1 of block 0x40, then read the whole block back.
  task automatic test_write_read();
    int lat, bb, eb;
    logic e;
    logic [511:0] exp;
    do_req(1'b0, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 1'b0, lat, bb, eb, e);
    checks++; if (lat !== 5) begin errors++; $display("FAIL write_latency: got %0d expected 5", lat); end
    checks++; if (bb !== 0 || eb !== 0 || e !== 1'b0) begin errors++; $display("FAIL write_flags: busy_low %0d err %0d/%b expected 0 0 0", bb, eb, e); end
    do_req(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, lat, bb, eb, e);
    exp = '0;
    exp[63:32] = 32'hDEAD_BEEF;
    checks++; if (lat !== 21) begin errors++; $display("FAIL wr_rd_latency: got %0d expected 21", lat); end
    checks++; if (main_mem_data_in !== exp) begin errors++; $display("FAIL wr_rd_data: got %h expected %h", main_mem_data_in, exp); end
  endtask

  // Both requests high: only the read is served and storage keeps its value.
  task automatic test_priority();
    int lat, bb, eb;
    logic e;
    do_req(1'b0, 1'b1, 32'h0000_0080, 32'h0BAD_F00D, 1'b0, lat, bb, eb, e);
    checks++; if (lat !== 5) begin errors++; $display("FAIL prio_setup_latency: got %0d expected 5", lat); end
    do_req(1'b1, 1'b1, 32'h0000_0080, 32'h1111_1111, 1'b0, lat, bb, eb, e);
    checks++; if (lat !== 21) begin errors++; $display("FAIL prio_latency: got %0d expected 21 (read served)", lat); end
    checks++; if (main_mem_data_in[31:0] !== 32'h0BAD_F00D) begin errors++; $display("FAIL prio_data: got %h expected 0badf00d", main_mem_data_in[31:0]); end
    do_req(1'b1, 1'b0, 32'h0000_0080, 32'h0, 1'b0, lat, bb, eb, e);
    checks++; if (main_mem_data_in[31:0] !== 32'h0BAD_F00D) begin errors++; $display("FAIL prio_no_write: got %h expected 0badf00d", main_mem_data_in[31:0]); end
  endtask

  // Reset during WR_WAIT: no completion, and the write is discarded.
  task automatic test_reset_abort();
    int lat, bb, eb, pulses;
    logic e;
    main_mem_addr      = 32'h0000_0100;
    main_mem_data_out  = 32'h1234_5678;
    main_mem_write_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (mm_busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b expected 1", mm_busy); end
    rst = 1'b1;
    main_mem_write_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (mm_busy !== 1'b0 || main_mem_ready !== 1'b0) begin errors++; $display("FAIL abort_state: busy %b ready %b expected 0 0", mm_busy, main_mem_ready); end
    checks++; if (main_mem_data_in !== 512'h0) begin errors++; $display("FAIL abort_data_clear: got %h expected 0", main_mem_data_in); end
    pulses = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (main_mem_ready === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_ready: got %0d pulses expected 0", pulses); end
    do_req(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b0, lat, bb, eb, e);
    checks++; if (lat !== 21) begin errors++; $display("FAIL abort_read_latency: got %0d expected 21", lat); end
    checks++; if (main_mem_data_in[31:0] !== 32'h0) begin errors++; $display("FAIL abort_discarded: got %h expected 0", main_mem_data_in[31:0]); end
  endtask

  // Write to 16 KB + 4: either flagged and dropped, or wrapped onto word 1.
  task automatic test_range();
    int lat, bb, eb;
    logic e;
    logic [31:0] exp_w1;
    exp_w1 = EXP_OOR_ERR ? 32'h0 : 32'hA5A5_A5A5;
    do_req(1'b0, 1'b1, 32'h0000_4004, 32'hA5A5_A5A5, 1'b0, lat, bb, eb, e);
    checks++; if (lat !== 5) begin errors++; $display("FAIL range_wr_latency: got %0d expected 5", lat); end
    checks++; if (e !== EXP_OOR_ERR || eb !== 0) begin errors++; $display("FAIL range_wr_err: at_ready %b stray %0d expected %b 0", e, eb, EXP_OOR_ERR); end
    do_req(1'b1, 1'b0, 32'h0000_0004, 32'h0, 1'b0, lat, bb, eb, e);
    checks++; if (main_mem_data_in[63:32] !== exp_w1) begin errors++; $display("FAIL range_rd_word1: got %h expected %h", main_mem_data_in[63:32], exp_w1); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL range_inrange_err: got %b expected 0", e); end
    do_req(1'b1, 1'b0, 32'h0000_4000, 32'h0, 1'b0, lat, bb, eb, e);
    checks++; if (lat !== 21 || e !== EXP_OOR_ERR) begin errors++; $display("FAIL range_oor_read: lat %0d err %b expected 21 %b", lat, e, EXP_OOR_ERR); end
    checks++; if (main_mem_data_in[63:32] !== exp_w1) begin errors++; $display("FAIL range_oor_read_data: got %h expected %h", main_mem_data_in[63:32], exp_w1); end
    @(posedge clk); #1;
    checks++; if (mm_err !== 1'b0) begin errors++; $display("FAIL range_err_clear: got %b expected 0", mm_err); end
  endtask

  // Toggling read_req mid-transaction changes nothing: one ready pulse only.
  task automatic test_toggle();
    int lat, bb, eb, pulses;
    logic e;
    do_req(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b1, lat, bb, eb, e);
    checks++; if (lat !== 21) begin errors++; $display("FAIL toggle_latency: got %0d expected 21", lat); end
    checks++; if (main_mem_data_in[63:32] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL toggle_data: got %h expected deadbeef", main_mem_data_in[63:32]); end
    pulses = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (main_mem_ready === 1'b1 || mm_busy === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL toggle_extra_activity: got %0d cycles expected 0", pulses); end
  endtask

  // Write immediately followed by a read of the same word, minimum gap.
  task automatic test_back_to_back();
    int lat_w, lat_r, bb, eb;
    logic e;
    do_req(1'b0, 1'b1, 32'h0000_01C8, 32'hCAFE_F00D, 1'b0, lat_w, bb, eb, e);
    do_req(1'b1, 1'b0, 32'h0000_01C0, 32'h0, 1'b0, lat_r, bb, eb, e);
    checks++; if (lat_w !== 5 || lat_r !== 21) begin errors++; $display("FAIL b2b_latency: got %0d/%0d expected 5/21", lat_w, lat_r); end
    checks++; if (main_mem_data_in[95:64] !== 32'hCAFE_F00D || main_mem_data_in[63:0] !== 64'h0) begin errors++; $display("FAIL b2b_data: got %h expected word2 cafef00d", main_mem_data_in[95:0]); end
  endtask

  initial begin
    test_reset();
    test_read_cold();
    test_write_read();
    test_priority();
    test_reset_abort();
    test_range();
    test_toggle();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
